// File: rtl/viterbi_pkg.sv
// Shared Viterbi-link definitions: trellis/symbol types, generator taps,
// encoder FSM states and the single branch function both link ends score with.
package viterbi_pkg;

  typedef logic [1:0] trellis_state_t;
  typedef logic [1:0] symbol_t;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DATA  = 2'b01,
    ST_TAIL1 = 2'b10,
    ST_TAIL2 = 2'b11
  } enc_state_e;

  // Taps ordered {u, most recent bit, older bit} so G0/G1 read MSB-first as written.
  function automatic symbol_t branch_symbol(input trellis_state_t s, input logic u);
    logic [2:0] taps;
    taps = {u, s[0], s[1]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic trellis_state_t branch_next(input trellis_state_t s, input logic u);
    return {s[0], u};
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Valid/ready input bit stream and output symbol stream of the convolutional encoder.
interface conv_encoder_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );

endinterface

// File: rtl/conv_enc_trellis.sv
// One trellis branch: (state, input bit) -> (code symbol, next state).
module conv_enc_trellis
  import viterbi_pkg::*;
(
  input  trellis_state_t s_i,
  input  logic           u_i,
  output symbol_t        sym_o,
  output trellis_state_t s_next_o
);

  assign sym_o    = branch_symbol(s_i, u_i);
  assign s_next_o = branch_next(s_i, u_i);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with a single output register.
// CONV_ENCODER_TAIL_EN adds two zero tail symbols per frame (trellis back to 00).
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  conv_encoder_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] sym_cnt
);

  enc_state_e     state_q, state_d;
  trellis_state_t s_q, s_d;
  logic           out_valid_q, out_valid_d;
  symbol_t        out_sym_q, out_sym_d;
  logic           out_last_q, out_last_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;

  logic           slot_free_s;
  logic           in_ready_s;
  logic           accept_s;
  logic           load_s;
  logic           u_s;
  logic           last_s;
  symbol_t        sym_s;
  trellis_state_t s_next_s;

  assign slot_free_s = ~out_valid_q | bus.out_ready;
  assign in_ready_s  = ~rst & slot_free_s & ((state_q == ST_IDLE) | (state_q == ST_DATA));
  assign accept_s    = bus.in_valid & in_ready_s;

  conv_enc_trellis u_trellis (
    .s_i      (s_q),
    .u_i      (u_s),
    .sym_o    (sym_s),
    .s_next_o (s_next_s)
  );

  // FSM: decides whether a symbol is loaded this cycle and from which input bit
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    u_s     = 1'b0;
    last_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept_s) begin
          load_s = 1'b1;
          u_s    = bus.in_bit;
`ifdef CONV_ENCODER_TAIL_EN
          last_s  = 1'b0;
          state_d = bus.in_last ? ST_TAIL1 : ST_DATA;
`else
          last_s  = bus.in_last;
          state_d = bus.in_last ? ST_IDLE : ST_DATA;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef CONV_ENCODER_TAIL_EN
      ST_TAIL1: begin
        if (slot_free_s) begin
          load_s  = 1'b1;
          state_d = ST_TAIL2;
        end else begin
          state_d = state_q;
        end
      end
      ST_TAIL2: begin
        if (slot_free_s) begin
          load_s  = 1'b1;
          last_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot, trellis state and per-frame symbol counter next values
  always_comb begin
    s_d         = s_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_sym_d   = sym_s;
      out_last_d  = last_s;
      s_d         = s_next_s;
    end else begin
      s_d = s_q;
    end
    if (out_valid_q & bus.out_ready) begin
      sym_cnt_d = out_last_q ? '0 : sym_cnt_q + CNT_W'(1);
    end else begin
      sym_cnt_d = sym_cnt_q;
    end
  end

  // State registers with synchronous reset; a reset mid-frame drops the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= 2'b00;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != ST_IDLE) | out_valid_q;
  assign sym_cnt       = sym_cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames plus random frames with
// random backpressure, checked against a table-driven trellis model.
module tb_conv_encoder;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] sym_cnt;

  conv_encoder_if bus ();

  conv_encoder #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .sym_cnt (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  logic [1:0]  tab [4][2];
  int          m_s;
  logic [2:0]  exp_q [$];
  logic [15:0] exp_cnt;
  bit          visited [4][2];
  logic [1:0]  got_sym [$];
  logic        got_last [$];
  logic [2:0]  ref_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Encoder model: symbol table lookup, state is the last two bits as a number.
  task automatic model_accept(input logic u, input logic last);
    int ui;
    ui = int'(u);
    visited[m_s][ui] = 1'b1;
`ifdef CONV_ENCODER_TAIL_EN
    exp_q.push_back({1'b0, tab[m_s][ui]});
    m_s = (m_s * 2 + ui) % 4;
    if (last) begin
      exp_q.push_back({1'b0, tab[m_s][0]});
      m_s = (m_s * 2) % 4;
      exp_q.push_back({1'b1, tab[m_s][0]});
      m_s = (m_s * 2) % 4;
    end
`else
    exp_q.push_back({last, tab[m_s][ui]});
    m_s = (m_s * 2 + ui) % 4;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_s = 0;
    exp_q.delete();
    exp_cnt = 16'd0;
  endtask

  task automatic run_frame(input int len, input logic [63:0] bits,
                           input logic [63:0] stall_mask, input bit rnd_stall);
    int idx, cyc, first_out, last_out, nsym;
    logic held_v;
    logic [2:0] held, e;
    idx = 0; cyc = 0; first_out = -1; last_out = -1; nsym = 0; held_v = 1'b0; held = 3'd0;
    got_sym.delete();
    got_last.delete();
    @(posedge clk);
    #1;
    while (cyc < 2000) begin
      bus.in_valid  = (idx < len);
      bus.in_bit    = (idx < len) ? bits[idx] : 1'b0;
      bus.in_last   = (idx == len - 1);
      bus.out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : ((cyc < 64) ? !stall_mask[cyc] : 1'b1);
      @(negedge clk);
      check("sym_cnt", sym_cnt, exp_cnt);
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_sym", {bus.out_last, bus.out_sym}, held);
      end
      if (bus.out_valid) check("busy_frame", busy, 1'b1);
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", bus.in_ready, 1'b0);
        held_v = 1'b1;
        held = {bus.out_last, bus.out_sym};
      end
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bzzz;
        check("sym", {bus.out_last, bus.out_sym}, e);
        got_sym.push_back(bus.out_sym);
        got_last.push_back(bus.out_last);
        nsym++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        exp_cnt = e[2] ? 16'd0 : exp_cnt + 16'd1;
      end
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_bit, bus.in_last);
        idx++;
      end
      cyc++;
      if (idx == len && exp_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("frame_done", (idx == len) && (exp_q.size() == 0), 1'b1);
    check("busy_end", busy, 1'b0);
    check("cnt_end", sym_cnt, 16'd0);
    if (!rnd_stall && stall_mask == 64'd0) check("no_bubble", last_out - first_out + 1, nsym);
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_s = 0; exp_cnt = 16'd0;
    tab = '{'{2'b00, 2'b11}, '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b01, 2'b10}};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_after", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sym", bus.out_sym, 2'b00);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sym_cnt", sym_cnt, 16'd0);

    // Frame 1,0,1,1 with no stalls
    run_frame(4, 64'hD, 64'd0, 1'b0);
`ifdef CONV_ENCODER_TAIL_EN
    check("f1_len", got_sym.size(), 6);
    if (got_sym.size() == 6) begin
      check("f1_s0", got_sym[0], 2'b11); check("f1_s1", got_sym[1], 2'b10);
      check("f1_s2", got_sym[2], 2'b00); check("f1_s3", got_sym[3], 2'b01);
      check("f1_s4", got_sym[4], 2'b01); check("f1_s5", got_sym[5], 2'b11);
      for (int i = 0; i < 6; i++) check("f1_last", got_last[i], (i == 5));
    end
`else
    check("f1_len", got_sym.size(), 4);
    if (got_sym.size() == 4) begin
      check("f1_s0", got_sym[0], 2'b11); check("f1_s1", got_sym[1], 2'b10);
      check("f1_s2", got_sym[2], 2'b00); check("f1_s3", got_sym[3], 2'b01);
      for (int i = 0; i < 4; i++) check("f1_last", got_last[i], (i == 3));
    end
`endif

    // Next frame, single bit 0: state carried over only without tails
    run_frame(1, 64'h0, 64'd0, 1'b0);
`ifdef CONV_ENCODER_TAIL_EN
    check("f2_s0", got_sym[0], 2'b00);
`else
    check("f2_s0", got_sym[0], 2'b01);
`endif

    // Backpressure: stalled run must match the unstalled one
    do_reset();
    run_frame(8, 64'hA7, 64'd0, 1'b0);
    ref_q.delete();
    for (int i = 0; i < got_sym.size(); i++) ref_q.push_back({got_last[i], got_sym[i]});
    do_reset();
    run_frame(8, 64'hA7, 64'h38, 1'b0);
    check("bp_len", got_sym.size(), ref_q.size());
    for (int i = 0; i < got_sym.size() && i < ref_q.size(); i++)
      check("bp_seq", {got_last[i], got_sym[i]}, ref_q[i]);

    // All eight trellis branches from a chosen prefix
    do_reset();
    for (int s = 0; s < 4; s++) begin
      visited[s][0] = 1'b0;
      visited[s][1] = 1'b0;
    end
    run_frame(10, 64'h14E, 64'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      check("cover_u0", visited[s][0], 1'b1);
      check("cover_u1", visited[s][1], 1'b1);
    end

    // Reset while the first tail symbol is pending
    do_reset();
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_last = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sym_cnt", sym_cnt, 16'd0);
    m_s = 0; exp_q.delete(); exp_cnt = 16'd0;
    run_frame(1, 64'h1, 64'd0, 1'b0);
    check("post_rst_s0", got_sym[0], 2'b11);

    // Single-bit frame, bit 0
    run_frame(1, 64'h0, 64'd0, 1'b0);
`ifdef CONV_ENCODER_TAIL_EN
    check("single_len", got_sym.size(), 3);
    if (got_sym.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("single_sym", got_sym[i], 2'b00);
        check("single_last", got_last[i], (i == 2));
      end
    end
`else
    check("single_len", got_sym.size(), 1);
    check("single_sym", got_sym[0], 2'b10);
    check("single_last", got_last[0], 1'b1);
`endif

    // Random frames with random backpressure
    for (int f = 0; f < 20; f++)
      run_frame($urandom_range(1, 24), {$urandom, $urandom}, 64'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder (generators G0 = 111, G1 = 101) forming the transmit end of the Viterbi link. It accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per information bit. With zero-termination it appends two tail symbols that return the trellis to state 00, which is the state the decoder's traceback starts from. Its trellis is, by construction, the one the decoder's branch-metric unit scores against.

## Interface
- CNT_W, 16, width of the per-frame symbol counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit/in_last valid
- in_ready  out  1  encoder accepts input this cycle
- in_bit  in  1  information bit u
- in_last  in  1  marks last information bit of frame
- out_valid  out  1  out_sym valid
- out_ready  in  1  downstream accepts out_sym
- out_sym  out  2  code symbol {c0, c1}
- out_last  out  1  marks final symbol of frame
- busy  out  1  frame in progress (FSM not IDLE, or out_valid high)
- sym_cnt  out  CNT_W  symbols accepted downstream in current frame

## Operation
- Trellis state s[1:0] = {older bit, most recent bit}; reset value 00.
- c0 = u ^ s[1] ^ s[0]; c1 = u ^ s[1]; next s = {s[0], u}.
- Required mapping (u=0 / u=1): s=00 → 00/11; s=01 → 10/01; s=10 → 11/00; s=11 → 01/10.
- Single output register. Slot free when out_valid=0 or out_ready=1.
- FSM states: IDLE, DATA, TAIL1, TAIL2.
  - IDLE/DATA: in_ready = slot free. On in_valid & in_ready: register symbol, update s, go DATA; if in_last, go TAIL1.
  - TAIL1: in_ready=0; when slot free, emit symbol for u=0, go TAIL2.
  - TAIL2: in_ready=0; when slot free, emit symbol for u=0 with out_last=1, go IDLE. s is 00 after this by construction.
- sym_cnt increments on each out_valid & out_ready; clears to 0 in the cycle after the out_last symbol is accepted. Wraps modulo 2^CNT_W; no saturation.
- out_sym/out_last held stable while out_valid & !out_ready.
- rst mid-frame: FSM→IDLE, s→00, out_valid→0, sym_cnt→0; the partial frame is discarded; no tail is emitted.

## Timing
- Reset values: in_ready=0 during rst cycle, 1 the cycle after; out_valid=0, out_sym=00, out_last=0, busy=0, sym_cnt=0.
- Latency: input accepted at edge N → out_valid at edge N (visible cycle N+1). Throughput 1 symbol/cycle with out_ready held high.
- Tail symbols follow last data symbol back-to-back when out_ready=1: frame of L bits yields L+2 symbols in L+2 cycles.
- in_ready is combinational from out_valid/out_ready and FSM state; no combinational path from in_valid to out_*.
- Simultaneous out_ready & new input acceptance in same cycle: old symbol retired, new one loaded; no bubble.

## Configuration
- CONV_ENCODER_TAIL_EN defined: zero-termination as above (TAIL1/TAIL2 active; out_last on second tail symbol).
- Undefined: no tail states; out_last accompanies the symbol of the in_last bit; s is NOT cleared between frames (continuous stream, cleared only by rst); frame yields exactly L symbols.

## Structure
- Shared viterbi_pkg: trellis state typedef (2-bit), symbol typedef (2-bit), generator constants G0=3'b111, G1=3'b101, and FSM state enum.
- Sub-module conv_enc_trellis: combinational (s, u) → (out_sym, next s); the same function is used by the decoder's branch-metric table, keeping encoder and decoder trellises identical.

## Test plan
- TAIL_EN, bits 1,0,1,1 (last on 4th), out_ready=1 → symbols 11,10,00,01,01,11; out_last on 6th only; sym_cnt returns to 0.
- TAIL_EN off, same input → 11,10,00,01 with out_last on 4th; next frame bit 0 → 01 (state 11 carried over).
- Backpressure: out_ready=0 for 3 cycles mid-frame → out_sym stable, in_ready=0, no bits lost or duplicated; sequence identical to unstalled run.
- Exhaustive trellis: drive all 8 (s,u) pairs via chosen prefixes → mapping table above holds for each.
- rst asserted during TAIL1 → next cycle out_valid=0, busy=0, sym_cnt=0; new frame bit 1 → 11.
- Single-bit frame, bit 0 → 00,00,00 with out_last on 3rd; busy low the cycle after acceptance.
